// File: rtl/inst_ram_responder_if.sv
// Fetch-side SRAM-style request/response bundle for the instruction RAM.
interface inst_ram_responder_if;
   logic        inst_ram_en;
   logic [31:0] inst_ram_addr;
   logic [3:0]  inst_ram_w_en;
   logic [31:0] inst_ram_w_data;
   logic [31:0] inst_ram_r_data;
   logic        inst_ram_err;
   logic        init_done;

   modport master (
      output inst_ram_en, inst_ram_addr, inst_ram_w_en, inst_ram_w_data,
      input  inst_ram_r_data, inst_ram_err, init_done
   );

   modport slave (
      input  inst_ram_en, inst_ram_addr, inst_ram_w_en, inst_ram_w_data,
      output inst_ram_r_data, inst_ram_err, init_done
   );
endinterface

// File: rtl/inst_ram_responder.sv
// Instruction RAM with 1-cycle read latency, NOP fill sweep after reset and range flagging.
// Define INST_RAM_WRITE_FIRST_EN for write-first read data on writes; read-first otherwise.
module inst_ram_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
   parameter logic [31:0] FILL_WORD  = 32'h03400000
) (
   input  logic                 clk,
   input  logic                 reset,
   inst_ram_responder_if.slave  bus
);

   localparam int unsigned           DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] LAST_IDX  = {DEPTH_LOG2{1'b1}};
   localparam logic [DEPTH_LOG2-1:0] IDX_ONE   = DEPTH_LOG2'(1);
   localparam logic [29:0]           BASE_WORD = 30'(BASE_ADDR >> 2);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   function automatic logic [31:0] merge_lanes(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  lane_en
   );
      logic [31:0] result;
      result = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lane_en[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            result[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return result;
   endfunction

   logic [31:0]           mem_r [DEPTH];
   state_t                state_r, state_s;
   logic [DEPTH_LOG2-1:0] cnt_r, cnt_s;
   logic [31:0]           r_data_r, r_data_s;
   logic                  err_r, err_s;
   logic                  init_done_r, init_done_s;

   logic [29:0]           word_addr_s;
   logic                  in_range_s;
   logic                  is_write_s;
   logic [DEPTH_LOG2-1:0] idx_s;
   logic [31:0]           old_word_s;
   logic [31:0]           merged_s;
   logic                  mem_we_s;
   logic [DEPTH_LOG2-1:0] mem_idx_s;
   logic [31:0]           mem_wdata_s;

   // Address decode; the byte offset bits fall away in the shift.
   assign word_addr_s = 30'(bus.inst_ram_addr >> 2);
   assign in_range_s  = (word_addr_s[29:DEPTH_LOG2] == BASE_WORD[29:DEPTH_LOG2]);
   assign idx_s       = word_addr_s[DEPTH_LOG2-1:0];
   assign is_write_s  = (bus.inst_ram_w_en != 4'b0000);
   assign old_word_s  = mem_r[idx_s];
   assign merged_s    = merge_lanes(old_word_s, bus.inst_ram_w_data, bus.inst_ram_w_en);

   // Next-state, sweep counter, array write port and next output values.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      r_data_s    = r_data_r;
      err_s       = err_r;
      init_done_s = init_done_r;
      mem_we_s    = 1'b0;
      mem_idx_s   = idx_s;
      mem_wdata_s = merged_s;
      case (state_r)
         ST_INIT: begin
            mem_we_s    = 1'b1;
            mem_idx_s   = cnt_r;
            mem_wdata_s = FILL_WORD;
            r_data_s    = FILL_WORD;
            err_s       = 1'b0;
            if (cnt_r == LAST_IDX) begin
               state_s     = ST_READY;
               init_done_s = 1'b1;
            end else begin
               cnt_s = cnt_r + IDX_ONE;
            end
         end
         ST_READY: begin
            if (bus.inst_ram_en) begin
               if (in_range_s) begin
                  err_s = 1'b0;
                  if (is_write_s) begin
                     mem_we_s = 1'b1;
`ifdef INST_RAM_WRITE_FIRST_EN
                     r_data_s = merged_s;
`else
                     r_data_s = old_word_s;
`endif
                  end else begin
                     r_data_s = old_word_s;
                  end
               end else begin
                  r_data_s = FILL_WORD;
                  err_s    = 1'b1;
               end
            end else begin
               r_data_s = r_data_r;
            end
         end
         default: begin
            state_s     = ST_INIT;
            cnt_s       = {DEPTH_LOG2{1'b0}};
            r_data_s    = FILL_WORD;
            err_s       = 1'b0;
            init_done_s = 1'b0;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_INIT;
         cnt_r       <= {DEPTH_LOG2{1'b0}};
         r_data_r    <= FILL_WORD;
         err_r       <= 1'b0;
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         r_data_r    <= r_data_s;
         err_r       <= err_s;
         init_done_r <= init_done_s;
      end
   end

   // Storage array; contents are only cleared by the sweep.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_idx_s] <= mem_wdata_s;
      end
   end

   assign bus.inst_ram_r_data = r_data_r;
   assign bus.inst_ram_err    = err_r;
   assign bus.init_done       = init_done_r;

endmodule

// File: doc/inst_ram_responder.md
# inst_ram_responder

Single-port, synchronous instruction RAM that answers the fetch stage's SRAM-style request (enable, address, byte write enables, write data) with one-cycle read latency. It sits between IF_stage and the instruction memory array at the top of myCPU. After reset it runs an initialisation sweep that fills every word with the LoongArch NOP. It also flags addresses outside the mapped window.

## Interface
Parameters:
- DEPTH_LOG2, 10: word-address width; the array holds 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h1c000000: byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.
- FILL_WORD, 32'h03400000: value written by the init sweep and returned while not ready or on error.

Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- inst_ram_en, in, 1: request enable (read when inst_ram_w_en==0, write otherwise).
- inst_ram_addr, in, 32: byte address; bits [1:0] are ignored.
- inst_ram_w_en, in, 4: byte-lane write enables; bit i covers data bits [8i+7:8i].
- inst_ram_w_data, in, 32: write data.
- inst_ram_r_data, out, 32: read data, registered.
- inst_ram_err, out, 1: registered; the request one cycle earlier was out of range.
- init_done, out, 1: high once the init sweep has finished.

## Operation
- FSM states:
  - INIT: entered on reset assertion. A DEPTH_LOG2-bit counter starts at 0 and writes FILL_WORD to word[counter] each cycle. At counter == 2^DEPTH_LOG2-1 the FSM moves to READY.
  - READY: terminal until the next reset.
- In INIT, requests are ignored: no array write, inst_ram_r_data=FILL_WORD, inst_ram_err=0.
- In READY:
  - In range means inst_ram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2].
  - Index = inst_ram_addr[DEPTH_LOG2+1:2].
  - Read: en=1, w_en=0, in range. Next cycle inst_ram_r_data=word[index], err=0.
  - Write: en=1, w_en!=0, in range. Only enabled lanes update at the clock edge. Next-cycle inst_ram_r_data follows the Configuration rule.
  - Out of range (en=1): no array write. Next cycle inst_ram_r_data=FILL_WORD, err=1.
  - en=0: inst_ram_r_data and err hold their previous values and the array is unchanged.
- Reset mid-operation, reset low in any state:
  - immediately: init_done=0, inst_ram_r_data=FILL_WORD, err=0, FSM=INIT, counter=0;
  - the sweep restarts from word 0 once reset releases.
- Array contents are not reset asynchronously; only the sweep clears them.

## Timing
- Reset values: inst_ram_r_data=FILL_WORD, inst_ram_err=0, init_done=0.
- First sweep write happens at the first rising edge with reset high.
- init_done rises at the edge that performs the last sweep write, i.e. the 2^DEPTH_LOG2-th edge after release.
- Read latency is exactly 1 cycle: address presented in cycle N, data valid in cycle N+1.
- Back-to-back requests are accepted every cycle and there is no stall output.
- This matches IF_stage, which presents next_PC as the address and consumes the data one cycle later.
- init_done must gate the fetch-valid path at the top level; this block does not back-pressure.

## Configuration
- INST_RAM_WRITE_FIRST_EN:
  - defined: write-first. After a write, inst_ram_r_data shows the merged new word (enabled lanes from w_data, other lanes from the old word).
  - undefined: read-first. After a write, inst_ram_r_data shows the word's contents before the write.
  - The array update is identical in both builds.

## Test plan
- Reset and sweep, DEPTH_LOG2=4: release reset, then read words 0..15.
  - init_done rises on the 16th edge after release.
  - Every word reads 32'h03400000 with err=0.
- Read latency: write 32'h12345678 to 0x1c000008, then read 0x1c000008 in cycle N.
  - inst_ram_r_data=32'h12345678 in cycle N+1.
  - inst_ram_r_data holds that value while en=0.
- Byte lanes: word 0x1c000004=32'hAABBCCDD; write w_en=4'b0101, w_data=32'h11223344.
  - Following read returns 32'hAA22CC44.
  - Write-cycle r_data=32'hAA22CC44 with INST_RAM_WRITE_FIRST_EN defined, 32'hAABBCCDD without it.
- Out of range: read 0x1d000000.
  - Next cycle err=1 and r_data=FILL_WORD.
  - Write to 0x1d000000 leaves every in-range word unchanged.
- Reset mid-sweep: assert reset after 5 sweep cycles, hold 2 cycles, release.
  - init_done=0 and r_data=FILL_WORD immediately on assertion.
  - Sweep restarts at word 0; init_done rises 16 edges after release.
- Request during INIT: issue a write of 32'hDEADBEEF to 0x1c000000 while init_done=0.
  - After init, word 0 reads 32'h03400000.
